// File: rtl/stopwatch_seg_display_pkg.sv
// Shared types and constants for the MM:SS stopwatch and its seven-segment scan driver.
package stopwatch_seg_display_pkg;

    localparam int unsigned DIGIT_W  = 4;
    localparam int unsigned SEG_W    = 7;
    localparam int unsigned AN_W     = 4;
    localparam int unsigned SCAN_W   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } sw_state_t;

    typedef struct packed {
        logic [DIGIT_W-1:0] m10;
        logic [DIGIT_W-1:0] m1;
        logic [DIGIT_W-1:0] s10;
        logic [DIGIT_W-1:0] s1;
    } bcd_time_t;

    localparam logic [DIGIT_W-1:0] BCD_MAX_UNITS = 4'd9;
    localparam logic [DIGIT_W-1:0] BCD_MAX_TENS  = 4'd5;

    // Active-low cathode patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    // One-second ripple-carry increment; 59:59 rolls to 00:00
    function automatic bcd_time_t bcd_inc(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.s1 < BCD_MAX_UNITS) begin
            r.s1 = t.s1 + 4'd1;
        end else begin
            r.s1 = '0;
            if (t.s10 < BCD_MAX_TENS) begin
                r.s10 = t.s10 + 4'd1;
            end else begin
                r.s10 = '0;
                if (t.m1 < BCD_MAX_UNITS) begin
                    r.m1 = t.m1 + 4'd1;
                end else begin
                    r.m1 = '0;
                    if (t.m10 < BCD_MAX_TENS) r.m10 = t.m10 + 4'd1;
                    else                      r.m10 = '0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_seg_display_seg7_decode.sv
// BCD digit to active-low seven-segment pattern; blank or non-decimal input gives all-off.
module seg7_decode
    import stopwatch_seg_display_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    input  logic               blank,
    output logic [SEG_W-1:0]   seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    seg_c = SEG_0;
                4'd1:    seg_c = SEG_1;
                4'd2:    seg_c = SEG_2;
                4'd3:    seg_c = SEG_3;
                4'd4:    seg_c = SEG_4;
                4'd5:    seg_c = SEG_5;
                4'd6:    seg_c = SEG_6;
                4'd7:    seg_c = SEG_7;
                4'd8:    seg_c = SEG_8;
                4'd9:    seg_c = SEG_9;
                default: seg_c = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/stopwatch_seg_display.sv
// MM:SS stopwatch driven by 1 Hz / ~10 kHz divider outputs, with a 4-digit multiplexed display.
module stopwatch_seg_display
    import stopwatch_seg_display_pkg::*;
#(
    parameter bit          LEADING_BLANK = 1'b1,
    parameter int unsigned DP_DIGIT      = 2
) (
    input  logic               CLOCK,
    input  logic               RESET_N,
    input  logic               SEC_CLK,
    input  logic               SCAN_CLK,
    input  logic               START_STOP,
    input  logic               CLEAR,
    output logic [AN_W-1:0]    AN,
    output logic [SEG_W-1:0]   SEG,
    output logic               DP,
    output logic [15:0]        TIME_BCD,
    output logic               RUNNING,
    output logic               WRAP
);

    logic              sec_prev;
    logic              scan_prev;
    logic              sec_tick_c;
    logic              scan_tick_c;
    sw_state_t         state;
    bcd_time_t         tm;
    logic [SCAN_W-1:0] scan_idx;
    logic              scan_on;
    logic [SCAN_W-1:0] shown_idx_c;
    logic [DIGIT_W-1:0] shown_digit_c;
    logic              blank_c;
    logic [SEG_W-1:0]  seg_c;

    assign sec_tick_c  = SEC_CLK  & ~sec_prev;
    assign scan_tick_c = SCAN_CLK & ~scan_prev;
    assign TIME_BCD    = tm;

    // Run/pause control and the BCD time counter; CLEAR wins over everything
    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            sec_prev <= 1'b1;
            state    <= ST_IDLE;
            tm       <= '0;
            RUNNING  <= 1'b0;
            WRAP     <= 1'b0;
        end else begin
            sec_prev <= SEC_CLK;
            WRAP     <= 1'b0;
            if (CLEAR) begin
                state   <= ST_IDLE;
                tm      <= '0;
                RUNNING <= 1'b0;
            end else begin
                if (state == ST_RUN && sec_tick_c) begin
                    tm   <= bcd_inc(tm);
                    WRAP <= (tm == 16'h5959);
                end
                if (START_STOP) begin
                    case (state)
                        ST_RUN: begin
                            state   <= ST_PAUSE;
                            RUNNING <= 1'b0;
                        end
                        default: begin
                            state   <= ST_RUN;
                            RUNNING <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    // Digit scan index; scan_on keeps the display dark until the first scan tick
    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            scan_prev <= 1'b1;
            scan_idx  <= '0;
            scan_on   <= 1'b0;
        end else begin
            scan_prev <= SCAN_CLK;
            if (scan_tick_c) begin
                scan_idx <= scan_idx + 2'd1;
                scan_on  <= 1'b1;
            end
        end
    end

    // The digit on show is the one the index just left, so the first tick lights digit 0
    always_comb begin
        shown_idx_c = scan_idx - 2'd1;
        case (shown_idx_c)
            2'd0:    shown_digit_c = tm.s1;
            2'd1:    shown_digit_c = tm.s10;
            2'd2:    shown_digit_c = tm.m1;
            default: shown_digit_c = tm.m10;
        endcase
        blank_c = LEADING_BLANK && (shown_idx_c == 2'd3) && (tm.m10 == 4'd0);
    end

    seg7_decode u_seg7_decode (
        .digit (shown_digit_c),
        .blank (blank_c),
        .seg_c (seg_c)
    );

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            AN  <= 4'b1111;
            SEG <= SEG_BLANK;
            DP  <= 1'b1;
        end else if (scan_on) begin
            AN  <= ~(4'b0001 << shown_idx_c);
            SEG <= seg_c;
            DP  <= (shown_idx_c != 2'(DP_DIGIT));
        end
    end

endmodule

// File: tb/tb_stopwatch_seg_display.sv
// Self-checking bench: vector table, hand-written corner sequences and random stimulus vs a seconds-count model.
module tb_stopwatch_seg_display;

    logic        CLOCK = 1'b0;
    logic        RESET_N;
    logic        SEC_CLK;
    logic        SCAN_CLK;
    logic        START_STOP;
    logic        CLEAR;
    logic [3:0]  AN;
    logic [6:0]  SEG;
    logic        DP;
    logic [15:0] TIME_BCD;
    logic        RUNNING;
    logic        WRAP;

    always #5 CLOCK = ~CLOCK;

    stopwatch_seg_display #(
        .LEADING_BLANK (1'b1),
        .DP_DIGIT      (2)
    ) dut (
        .CLOCK      (CLOCK),
        .RESET_N    (RESET_N),
        .SEC_CLK    (SEC_CLK),
        .SCAN_CLK   (SCAN_CLK),
        .START_STOP (START_STOP),
        .CLEAR      (CLEAR),
        .AN         (AN),
        .SEG        (SEG),
        .DP         (DP),
        .TIME_BCD   (TIME_BCD),
        .RUNNING    (RUNNING),
        .WRAP       (WRAP)
    );

    int checks = 0;
    int errors = 0;

    // Model: 0 idle, 1 run, 2 pause; time kept as elapsed seconds
    int m_state;
    int m_secs;
    int m_scans;
    bit m_wrap;
    logic [6:0] pat [10];

    typedef struct {
        bit          ss;
        bit          clr;
        bit          sec;
        logic [15:0] t;
        bit          run;
    } vec_t;
    vec_t tbl [12];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_bcd();
        int m;
        int s;
        m = m_secs / 60;
        s = m_secs % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic check_all(input string tag);
        logic [15:0] e;
        int          idx;
        logic [3:0]  d;
        logic [3:0]  ean;
        logic [6:0]  eseg;
        logic        edp;
        e = exp_bcd();
        if (m_scans == 0) begin
            ean  = 4'hF;
            eseg = 7'h7F;
            edp  = 1'b1;
        end else begin
            idx      = (m_scans - 1) % 4;
            d        = e[idx*4 +: 4];
            ean      = 4'hF;
            ean[idx] = 1'b0;
            eseg     = (idx == 3 && d == 4'd0) ? 7'h7F : pat[int'(d)];
            edp      = (idx == 2) ? 1'b0 : 1'b1;
        end
        check({tag, ".time"},    TIME_BCD, e);
        check({tag, ".running"}, 16'(RUNNING), 16'(m_state == 1));
        check({tag, ".wrap"},    16'(WRAP), 16'd0);
        check({tag, ".an"},      16'(AN), 16'(ean));
        check({tag, ".seg"},     16'(SEG), 16'(eseg));
        check({tag, ".dp"},      16'(DP), 16'(edp));
    endtask

    // One stimulus step: pulse the chosen inputs for a cycle, then a quiet cycle; entered at a negedge
    task automatic apply(input bit ss, input bit clr, input bit sec, input bit scan, input string tag);
        START_STOP = ss;
        CLEAR      = clr;
        SEC_CLK    = sec;
        SCAN_CLK   = scan;
        m_wrap     = 1'b0;
        if (clr) begin
            m_state = 0;
            m_secs  = 0;
        end else begin
            if (m_state == 1 && sec) begin
                m_secs++;
                if (m_secs == 3600) begin
                    m_secs = 0;
                    m_wrap = 1'b1;
                end
            end
            if (ss) m_state = (m_state == 1) ? 2 : 1;
        end
        if (scan) m_scans++;
        @(negedge CLOCK);
        check({tag, ".wrap_pulse"}, 16'(WRAP), 16'(m_wrap));
        START_STOP = 1'b0;
        CLEAR      = 1'b0;
        SEC_CLK    = 1'b0;
        SCAN_CLK   = 1'b0;
        @(negedge CLOCK);
        check_all(tag);
    endtask

    task automatic do_reset(input bit sec_lvl, input bit scan_lvl);
        RESET_N    = 1'b0;
        SEC_CLK    = sec_lvl;
        SCAN_CLK   = scan_lvl;
        START_STOP = 1'b0;
        CLEAR      = 1'b0;
        repeat (3) @(negedge CLOCK);
        check("rst.an",      16'(AN), 16'hF);
        check("rst.seg",     16'(SEG), 16'h7F);
        check("rst.dp",      16'(DP), 16'd1);
        check("rst.time",    TIME_BCD, 16'h0000);
        check("rst.running", 16'(RUNNING), 16'd0);
        check("rst.wrap",    16'(WRAP), 16'd0);
        RESET_N = 1'b1;
        m_state = 0;
        m_secs  = 0;
        m_scans = 0;
    endtask

    initial begin
        pat[0] = 7'b1000000; pat[1] = 7'b1111001; pat[2] = 7'b0100100; pat[3] = 7'b0110000;
        pat[4] = 7'b0011001; pat[5] = 7'b0010010; pat[6] = 7'b0000010; pat[7] = 7'b1111000;
        pat[8] = 7'b0000000; pat[9] = 7'b0010000;

        // {ss, clr, sec, expected time, expected running}, starting from a cleared IDLE
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 16'h0001, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 16'h0002, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 16'h0003, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 16'h0004, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 16'h0004, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 16'h0004, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 16'h0005, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 16'h0000, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1};

        RESET_N = 1'b0; SEC_CLK = 1'b0; SCAN_CLK = 1'b0; START_STOP = 1'b0; CLEAR = 1'b0;
        do_reset(1'b0, 1'b0);
        @(negedge CLOCK);
        check("post_rst.an", 16'(AN), 16'hF);

        // Five scan ticks walk the anodes 0,1,2,3,0; digit 3 blanked at 00:00
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b0, 1'b0, 1'b1, "scan");
            if (i == 0) check("scan.first_an", 16'(AN), 16'b1110);
            if (i == 3) check("scan.blank_seg", 16'(SEG), 16'h7F);
        end

        apply(1'b0, 1'b1, 1'b0, 1'b0, "tbl_clear");
        for (int i = 0; i < 12; i++) begin
            apply(tbl[i].ss, tbl[i].clr, tbl[i].sec, 1'b1, "tbl");
            check("tbl.time_vec",    TIME_BCD, tbl[i].t);
            check("tbl.running_vec", 16'(RUNNING), 16'(tbl[i].run));
        end

        // 75 seconds of running
        apply(1'b0, 1'b1, 1'b0, 1'b0, "s75_clear");
        apply(1'b1, 1'b0, 1'b0, 1'b0, "s75_start");
        for (int i = 0; i < 75; i++) apply(1'b0, 1'b0, 1'b1, (i % 3) == 0, "s75");
        check("s75.time_const", TIME_BCD, 16'h0115);
        check("s75.running_const", 16'(RUNNING), 16'd1);

        // Run on to 59:58, then across the rollover
        while (m_secs != 3598) apply(1'b0, 1'b0, 1'b1, m_secs > 3500, "preload");
        apply(1'b0, 1'b0, 1'b1, 1'b1, "to5959");
        check("wrap.time_5959", TIME_BCD, 16'h5959);
        apply(1'b0, 1'b0, 1'b1, 1'b1, "wrap");
        check("wrap.time_0000", TIME_BCD, 16'h0000);
        check("wrap.running",   16'(RUNNING), 16'd1);

        // Pause coincident with a seconds tick at 00:03
        apply(1'b0, 1'b1, 1'b0, 1'b0, "pz_clear");
        apply(1'b1, 1'b0, 1'b0, 1'b0, "pz_start");
        for (int i = 0; i < 3; i++) apply(1'b0, 1'b0, 1'b1, 1'b0, "pz_run");
        apply(1'b1, 1'b0, 1'b1, 1'b0, "pz_stop");
        check("pz.time_0004", TIME_BCD, 16'h0004);
        check("pz.running",   16'(RUNNING), 16'd0);
        for (int i = 0; i < 3; i++) apply(1'b0, 1'b0, 1'b1, 1'b1, "pz_hold");
        check("pz.hold_0004", TIME_BCD, 16'h0004);

        // CLEAR coincident with START_STOP and a tick at 00:09
        apply(1'b0, 1'b1, 1'b0, 1'b0, "cl_clear");
        apply(1'b1, 1'b0, 1'b0, 1'b0, "cl_start");
        for (int i = 0; i < 9; i++) apply(1'b0, 1'b0, 1'b1, 1'b0, "cl_run");
        check("cl.time_0009", TIME_BCD, 16'h0009);
        apply(1'b1, 1'b1, 1'b1, 1'b0, "cl_all");
        check("cl.time_0", TIME_BCD, 16'h0000);
        check("cl.running", 16'(RUNNING), 16'd0);

        // Random mix of pulses against the model
        for (int i = 0; i < 400; i++) begin
            apply($urandom_range(0, 99) < 12, $urandom_range(0, 99) < 3,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
        end

        // Inputs held high across reset release give no tick until they cycle low
        do_reset(1'b1, 1'b1);
        START_STOP = 1'b1;
        @(negedge CLOCK);
        START_STOP = 1'b0;
        repeat (4) @(negedge CLOCK);
        check("hi.time",    TIME_BCD, 16'h0000);
        check("hi.an",      16'(AN), 16'hF);
        check("hi.running", 16'(RUNNING), 16'd1);
        SEC_CLK  = 1'b0;
        SCAN_CLK = 1'b0;
        @(negedge CLOCK);
        m_state = 1;
        apply(1'b0, 1'b0, 1'b1, 1'b1, "hi_rel");
        check("hi.time_0001", TIME_BCD, 16'h0001);
        check("hi.an_first",  16'(AN), 16'b1110);

        // Reset in the middle of running
        for (int i = 0; i < 7; i++) apply(1'b0, 1'b0, 1'b1, 1'b1, "mid_run");
        RESET_N = 1'b0;
        @(negedge CLOCK);
        check("mid_rst.an",      16'(AN), 16'hF);
        check("mid_rst.seg",     16'(SEG), 16'h7F);
        check("mid_rst.dp",      16'(DP), 16'd1);
        check("mid_rst.time",    TIME_BCD, 16'h0000);
        check("mid_rst.running", 16'(RUNNING), 16'd0);
        check("mid_rst.wrap",    16'(WRAP), 16'd0);
        RESET_N = 1'b1;
        m_state = 0;
        m_secs  = 0;
        m_scans = 0;
        apply(1'b0, 1'b0, 1'b1, 1'b0, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_seg_display.md
# stopwatch_seg_display

MM:SS stopwatch with a 4-digit seven-segment scan driver, fed by the divided clocks of the clock-divider stage.
- Consumes the 1 Hz divided clock (`SEC_CLK`) as the counting time base.
- Consumes the ~10 kHz divided clock (`SCAN_CLK`) as the digit-multiplex rate.
- Both inputs are registered square waves from the same 100 MHz `CLOCK` domain. They are used only as edge-detected enables, never as clocks.
- Drives the board anodes and cathodes directly.

## Interface
Parameters:
- `LEADING_BLANK`, default 1: when 1, minutes-tens digit is blanked while its value is 0.
- `DP_DIGIT`, default 2: digit index (0..3) whose decimal point is lit.

Ports:
- `CLOCK` in 1: 100 MHz system clock. Single clock for the whole block.
- `RESET_N` in 1: reset, synchronous, active-low.
- `SEC_CLK` in 1: 1 Hz square wave from the divider. Each rising edge is one seconds tick.
- `SCAN_CLK` in 1: ~10 kHz square wave from the divider. Each rising edge advances the scanned digit.
- `START_STOP` in 1: one-cycle pulse that toggles run/pause. Debounced upstream.
- `CLEAR` in 1: one-cycle pulse that zeroes the time and returns to IDLE.
- `AN` out 4: digit anodes, active-low, one-hot-low while scanning.
- `SEG` out 7: cathodes {g,f,e,d,c,b,a}, active-low.
- `DP` out 1: decimal-point cathode, active-low.
- `TIME_BCD` out 16: {m10,m1,s10,s1}, BCD.
- `RUNNING` out 1: high in RUN state.
- `WRAP` out 1: one-cycle pulse when the time rolls over from 59:59 to 00:00.

## Operation
Edge detection:
- Registers `sec_prev` and `scan_prev` hold the previous-cycle value of each input.
- `sec_tick = SEC_CLK & ~sec_prev`; `scan_tick = SCAN_CLK & ~scan_prev`.
- Both `_prev` registers reset to 1, so an input that is high at reset release gives no spurious tick.

State machine (states IDLE, RUN, PAUSE):
- IDLE + `START_STOP` → RUN.
- RUN + `START_STOP` → PAUSE.
- PAUSE + `START_STOP` → RUN.
- `CLEAR` in any state → IDLE with time 00:00.
- `CLEAR` has priority over `START_STOP` and `sec_tick` in the same cycle.
- `sec_tick` increments the time only in RUN, including the cycle in which `START_STOP` moves RUN → PAUSE. It is ignored in IDLE and PAUSE.
- `RUNNING` = (state == RUN).

BCD counter (s1 0–9, s10 0–5, m1 0–9, m10 0–5):
- Ripple carry on each increment.
- 59:59 + tick → 00:00 with `WRAP` = 1 for that one cycle. The state stays RUN.
- Digits never hold a value outside their range.

Scanner:
- 2-bit index 0→1→2→3→0, advancing on each `scan_tick` in every state.
- Index 0 = s1 on `AN[0]`; index 3 = m10 on `AN[3]`.
- Decode: digits 0–9 map to standard patterns, e.g. 0 = 1000000, 1 = 1111001, 8 = 0000000. Blank = 1111111.
- Blanking (`LEADING_BLANK`=1, index 3, m10 = 0): `SEG` = 1111111, `AN[3]` still driven low.
- `DP` = 0 only when index == `DP_DIGIT`.

## Timing
- Reset values:
  - `AN` = 1111, `SEG` = 1111111, `DP` = 1.
  - `TIME_BCD` = 0, `RUNNING` = 0, `WRAP` = 0.
  - State IDLE, scan index 0.
- `AN`, `SEG` and `DP` stay all-off after reset until the first `scan_tick`.
- `scan_tick`/`sec_tick` is combinational, true in the first cycle the input reads 1 after reading 0.
- The index or time register updates at the end of the tick cycle.
- `AN`/`SEG`/`DP` are registered from the index and time, so they change 1 cycle after the index updates.
- `TIME_BCD` and `WRAP` update on the same edge as the time register.
- `RUNNING` updates on the edge that ends the `START_STOP` cycle.
- The first increment after entering RUN happens at the next `SEC_CLK` rising edge, 0 to ~1 s later. No phase reset of the time base.
- `RESET_N` low mid-operation: all registers take reset values on that edge. The time is lost.
- Digit dwell is ~100 µs; frame period is ~400 µs.

## Structure
- Shared package holds:
  - State encoding (IDLE = 0, RUN = 1, PAUSE = 2).
  - Seven-segment pattern constants `SEG_0`..`SEG_9` and `SEG_BLANK`.
  - BCD digit limits (9, 5).
- One sub-module, `seg7_decode`: combinational 4-bit BCD plus blank → 7-bit active-low pattern.
- Edge detect, FSM, BCD counter and scanner stay in the top module.

## Test plan
- Reset then 5 `scan_tick`s:
  - `AN` = 1111 until the first tick.
  - Then `AN` sequence 1110, 1101, 1011, 0111, 1110.
  - `SEG` = 1000000 on digits 0–2; `SEG` = 1111111 on digit 3 (blanked).
  - `DP` = 0 only while `AN` = 1011.
- `START_STOP` then 75 `sec_tick`s → `TIME_BCD` = 0x0115, `RUNNING` = 1.
- Preload to 59:58 via ticks, then 2 ticks → `TIME_BCD` 0x5959, then 0x0000 with a single-cycle `WRAP` = 1; `RUNNING` stays 1.
- RUN, `START_STOP` coincident with `sec_tick` at 00:03 → `TIME_BCD` = 0x0004, state PAUSE. Further ticks leave 0x0004.
- `CLEAR` coincident with `START_STOP` and `sec_tick` at 00:09 → `TIME_BCD` = 0, state IDLE, `RUNNING` = 0, `WRAP` = 0.
- `SEC_CLK`/`SCAN_CLK` held high across reset release → no tick until each input goes low then high again. `RESET_N` low mid-RUN → all outputs at reset values on the next edge.
